// File: rtl/cnt_mod_sync.sv
// Synchronous modulo-MODULUS up/down counter with load, clear and one-shot mode.
// The terminal-count strobe tc is combinational so counters can be cascaded.
module cnt_mod_sync #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16
) (
    input  logic             ck,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    input  logic             up,
    input  logic             start,
    input  logic             oneshot,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULUS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             count_ok;

    assign term     = up ? Q_MAX : '0;
    assign at_term  = (q == term);
    assign count_ok = (state == RUN) & en & ~clr & ~ld & ~start;

    assign tc   = count_ok & at_term;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    // State and count register
    always_ff @(posedge ck or negedge res) begin
        if (!res) begin
            state <= IDLE;
            q     <= '0;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
        end
    end

    // Next state / next count, priority clr > ld > start > count
    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        if (clr) begin
            q_nxt     = '0;
            state_nxt = IDLE;
        end else if (ld) begin
            q_nxt = (d > Q_MAX) ? Q_MAX : d;
            if (state == DONE) begin
                state_nxt = IDLE;
            end
        end else if (start) begin
            case (state)
                IDLE: state_nxt = RUN;
                DONE: begin
                    state_nxt = RUN;
                    q_nxt     = up ? '0 : Q_MAX;
                end
                default: state_nxt = state;
            endcase
        end else if (count_ok) begin
            if (!at_term) begin
                q_nxt = up ? q + WIDTH'(1) : q - WIDTH'(1);
            end else if (!oneshot) begin
                q_nxt = up ? '0 : Q_MAX;
            end else begin
                state_nxt = DONE;
            end
        end
    end

endmodule
